rc4_prga_codec: RTL and testbench
=================================

Name: rc4_prga_codec

Overview:
- RC4 pseudo-random generation (PRGA) and data en/decoder; the consumer end of the key-scheduling (KSA) key generator.
- Receives the permuted 256-byte S-box over a write port, then XORs each incoming data byte with the next keystream byte.
- Encrypt and decrypt are the same operation.
- Sits between the key generator and the byte stream datapath.

Parameters:
- SBOX_DEPTH, 256, S-box entries; fixed, not intended for override
- DW, 8, data and S-box width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- sbox_wr_en  in  1  write one S-box entry this cycle
- sbox_wr_addr  in  8  S-box index
- sbox_wr_data  in  8  S-box value
- sbox_load_done  in  1  pulse: S-box transfer complete
- din  in  8  plaintext/ciphertext byte
- din_valid  in  1  din valid
- din_ready  out  1  block accepts din this cycle
- dout  out  8  din XOR keystream
- dout_valid  out  1  dout valid
- dout_ready  in  1  downstream accepts dout
- sbox_loaded  out  1  S-box present, keystream state active

Behaviour:
- Reset (async, rst=0):
  - S[m]=m for all m; i=0, j=0.
  - Outputs: dout=0, dout_valid=0, din_ready=0, sbox_loaded=0.
  - State = LOAD.
- States: LOAD, IDLE, SWAP, KEY, OUT.
- LOAD:
  - sbox_wr_en writes S[sbox_wr_addr]<=sbox_wr_data.
  - sbox_load_done -> IDLE; sbox_loaded<=1; i<=0, j<=0.
  - If wr_en and load_done occur in the same cycle, the write is applied first, then the state changes.
- IDLE:
  - din_ready=1 (registered; high exactly while in IDLE).
  - On din_valid: latch din; i<=i+1; si<=S[i+1]; -> SWAP.
- SWAP:
  - jn=j+si (mod 256); j<=jn.
  - S[i]<=S[jn]; S[jn]<=si. If i==jn, the entry is unchanged.
  - t<=si+S[jn] (mod 256, using pre-swap S[jn]); -> KEY.
- KEY:
  - dout<=din_latched ^ S[t] (post-swap S); dout_valid<=1; -> OUT.
- OUT:
  - Hold dout/dout_valid stable until dout_ready.
  - On dout_ready: dout_valid<=0; -> IDLE.
- Latency: din accept to dout_valid = 3 cycles.
- Throughput: at most 1 byte per 4 cycles, with dout_ready held high.
- Arithmetic: all i/j/t 8-bit, wrap mod 256. i increments from 255 to 0.
- Rekey:
  - sbox_wr_en seen in IDLE -> LOAD; that write is applied; sbox_loaded<=0; i,j cleared on the following load_done.
  - sbox_wr_en in SWAP/KEY/OUT is ignored; the producer must wait for sbox_loaded=1 with no byte in flight.
- sbox_load_done outside LOAD is ignored.
- Reset mid-operation: in-flight byte is discarded, dout_valid drops immediately, S returns to identity.
- No data is accepted before the first load_done (din_ready=0 in LOAD).

Decomposition:
- Shared package (rc4_pkg): state encodings (LOAD, IDLE, SWAP, KEY, OUT), DW, SBOX_DEPTH.
- Key-generator mode constants (INIT=2'b00, KEY_GENE=2'b01, EN_DE_CODE=2'b10) also live in rc4_pkg.
- One natural sub-module, rc4_sbox_ram:
  - 256x8 register array.
  - One external write port for load.
  - Dual swap-write port.
  - Three async read ports (S[i+1], S[jn], S[t]).
  - Identity reset.
- FSM, i/j/t registers and the XOR stay in the top.

Test Plan:
- Identity S-box (load S[m]=m, then load_done); din=0x00 three times -> dout=0x02, 0x05, 0x07; each dout_valid 3 cycles after its accept.
- Bench KSA model, key "Key"; load S; din=00 x10 -> dout EB 9F 77 81 B7 34 CA 72 A7 19.
- Same key, din "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> BB F3 16 E8 D9 40 AF 0A D3.
  - Reload S and feed the ciphertext -> original plaintext returned.
- Backpressure: hold dout_ready=0 for 5 cycles in OUT -> dout stable, dout_valid=1, din_ready=0 throughout; release -> next byte still correct per reference keystream.
- Assert rst low mid-KEY -> dout_valid=0, sbox_loaded=0 immediately; a din_valid pulse before reload -> no accept.
- Rekey: after 3 bytes, write a new S-box from IDLE -> sbox_loaded falls; after load_done, stream restarts with i=j=0 and matches the new-key model from byte 0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared constants and encodings for the RC4 key generator / PRGA codec pair.
package rc4_pkg;

  localparam int DW         = 8;
  localparam int SBOX_DEPTH = 256;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    IDLE = 3'd1,
    SWAP = 3'd2,
    KEY  = 3'd3,
    OUT  = 3'd4
  } prga_state_t;

  // Operating modes of the upstream key-scheduling block.
  typedef enum logic [1:0] {
    INIT       = 2'b00,
    KEY_GENE   = 2'b01,
    EN_DE_CODE = 2'b10
  } kg_mode_t;

endpackage

// File: rtl/rc4_prga_codec_if.sv
// S-box load port plus valid/ready byte stream between the key generator, datapath and codec.
interface rc4_prga_codec_if;
  import rc4_pkg::*;

  logic          sbox_wr_en;
  logic [DW-1:0] sbox_wr_addr;
  logic [DW-1:0] sbox_wr_data;
  logic          sbox_load_done;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          sbox_loaded;

  modport master (
    output sbox_wr_en, sbox_wr_addr, sbox_wr_data, sbox_load_done,
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, sbox_loaded
  );

  modport slave (
    input  sbox_wr_en, sbox_wr_addr, sbox_wr_data, sbox_load_done,
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, sbox_loaded
  );

endinterface

// File: rtl/rc4_sbox_ram.sv
// 256x8 S-box register file: load write port, paired swap write, three combinational reads.
module rc4_sbox_ram
  import rc4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_ext_we,
  input  logic [DW-1:0] i_ext_addr,
  input  logic [DW-1:0] i_ext_data,
  input  logic          i_swap_we,
  input  logic [DW-1:0] i_swap_addr_a,
  input  logic [DW-1:0] i_swap_data_a,
  input  logic [DW-1:0] i_swap_addr_b,
  input  logic [DW-1:0] i_swap_data_b,
  input  logic [DW-1:0] i_rd_addr_0,
  input  logic [DW-1:0] i_rd_addr_1,
  input  logic [DW-1:0] i_rd_addr_2,
  output logic [DW-1:0] o_rd_data_0,
  output logic [DW-1:0] o_rd_data_1,
  output logic [DW-1:0] o_rd_data_2
);

  logic [DW-1:0] w_mem [SBOX_DEPTH];

  // When both swap addresses coincide the two data values are equal, so port order is moot.
  generate
    for (genvar gi = 0; gi < SBOX_DEPTH; gi++) begin : g_entry
      logic [DW-1:0] r_entry;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_entry <= DW'(gi);
        else if (i_ext_we && (i_ext_addr == DW'(gi)))
          r_entry <= i_ext_data;
        else if (i_swap_we && (i_swap_addr_b == DW'(gi)))
          r_entry <= i_swap_data_b;
        else if (i_swap_we && (i_swap_addr_a == DW'(gi)))
          r_entry <= i_swap_data_a;
      end

      assign w_mem[gi] = r_entry;
    end
  endgenerate

  assign o_rd_data_0 = w_mem[i_rd_addr_0];
  assign o_rd_data_1 = w_mem[i_rd_addr_1];
  assign o_rd_data_2 = w_mem[i_rd_addr_2];

endmodule

// File: rtl/rc4_prga_codec.sv
// RC4 PRGA: holds the loaded S-box and XORs each accepted byte with the next keystream byte.
module rc4_prga_codec
  import rc4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rc4_prga_codec_if.slave bus
);

  prga_state_t   r_state, w_state_next;
  logic [DW-1:0] r_i, w_i_next;
  logic [DW-1:0] r_j, w_j_next;
  logic [DW-1:0] r_t, w_t_next;
  logic [DW-1:0] r_si, w_si_next;
  logic [DW-1:0] r_din, w_din_next;
  logic [DW-1:0] r_dout, w_dout_next;
  logic          r_dout_valid, w_dout_valid_next;
  logic          r_sbox_loaded, w_sbox_loaded_next;
  logic          r_din_ready;

  logic          w_ext_we;
  logic          w_swap_we;
  logic [DW-1:0] w_i_inc;
  logic [DW-1:0] w_jn;
  logic [DW-1:0] w_rd_inc;
  logic [DW-1:0] w_rd_jn;
  logic [DW-1:0] w_rd_t;

  assign w_i_inc = r_i + 8'd1;
  assign w_jn    = r_j + r_si;

  rc4_sbox_ram u_sbox (
    .clk           (clk),
    .rst           (rst),
    .i_ext_we      (w_ext_we),
    .i_ext_addr    (bus.sbox_wr_addr),
    .i_ext_data    (bus.sbox_wr_data),
    .i_swap_we     (w_swap_we),
    .i_swap_addr_a (r_i),
    .i_swap_data_a (w_rd_jn),
    .i_swap_addr_b (w_jn),
    .i_swap_data_b (r_si),
    .i_rd_addr_0   (w_i_inc),
    .i_rd_addr_1   (w_jn),
    .i_rd_addr_2   (r_t),
    .o_rd_data_0   (w_rd_inc),
    .o_rd_data_1   (w_rd_jn),
    .o_rd_data_2   (w_rd_t)
  );

  always_comb begin
    w_state_next       = r_state;
    w_i_next           = r_i;
    w_j_next           = r_j;
    w_t_next           = r_t;
    w_si_next          = r_si;
    w_din_next         = r_din;
    w_dout_next        = r_dout;
    w_dout_valid_next  = r_dout_valid;
    w_sbox_loaded_next = r_sbox_loaded;
    w_ext_we           = 1'b0;
    w_swap_we          = 1'b0;

    case (r_state)
      LOAD: begin
        w_ext_we = bus.sbox_wr_en;
        if (bus.sbox_load_done) begin
          w_state_next       = IDLE;
          w_sbox_loaded_next = 1'b1;
          w_i_next           = '0;
          w_j_next           = '0;
        end
      end
      IDLE: begin
        // A rekey write takes priority over a byte offered in the same cycle.
        if (bus.sbox_wr_en) begin
          w_ext_we           = 1'b1;
          w_sbox_loaded_next = 1'b0;
          w_state_next       = LOAD;
        end else if (bus.din_valid) begin
          w_din_next   = bus.din;
          w_i_next     = w_i_inc;
          w_si_next    = w_rd_inc;
          w_state_next = SWAP;
        end
      end
      SWAP: begin
        w_j_next     = w_jn;
        w_swap_we    = 1'b1;
        w_t_next     = r_si + w_rd_jn;
        w_state_next = KEY;
      end
      KEY: begin
        w_dout_next       = r_din ^ w_rd_t;
        w_dout_valid_next = 1'b1;
        w_state_next      = OUT;
      end
      OUT: begin
        if (bus.dout_ready) begin
          w_dout_valid_next = 1'b0;
          w_state_next      = IDLE;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= LOAD;
      r_i           <= '0;
      r_j           <= '0;
      r_t           <= '0;
      r_si          <= '0;
      r_din         <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_sbox_loaded <= 1'b0;
      r_din_ready   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_i           <= w_i_next;
      r_j           <= w_j_next;
      r_t           <= w_t_next;
      r_si          <= w_si_next;
      r_din         <= w_din_next;
      r_dout        <= w_dout_next;
      r_dout_valid  <= w_dout_valid_next;
      r_sbox_loaded <= w_sbox_loaded_next;
      r_din_ready   <= (w_state_next == IDLE);
    end
  end

  assign bus.din_ready   = r_din_ready;
  assign bus.dout        = r_dout;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.sbox_loaded = r_sbox_loaded;

endmodule

// File: tb/tb_rc4_prga_codec.sv
// Scoreboard bench for rc4_prga_codec against a reference RC4 KSA/PRGA model.
module tb_rc4_prga_codec;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  rc4_prga_codec_if bus ();

  rc4_prga_codec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         acc_q[$];

  // Reference RC4 state
  int ks_s [256];
  int ks_i;
  int ks_j;

  logic [7:0] exp_id  [3]  = '{8'h02, 8'h05, 8'h07};
  logic [7:0] exp_key0[10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] pt      [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct      [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_identity();
    for (int k = 0; k < 256; k++) ks_s[k] = k;
    ks_i = 0;
    ks_j = 0;
  endtask

  task automatic ksa(input string key);
    int j;
    int tmp;
    set_identity();
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + ks_s[k] + int'(key[k % key.len()])) % 256;
      tmp = ks_s[k]; ks_s[k] = ks_s[j]; ks_s[j] = tmp;
    end
  endtask

  task automatic ks_next(output logic [7:0] k);
    int tmp;
    ks_i = (ks_i + 1) % 256;
    ks_j = (ks_j + ks_s[ks_i]) % 256;
    tmp = ks_s[ks_i]; ks_s[ks_i] = ks_s[ks_j]; ks_s[ks_j] = tmp;
    k = 8'(ks_s[(ks_s[ks_i] + ks_s[ks_j]) % 256]);
  endtask

  // Transfers the model's current S-box; the last write carries load_done.
  task automatic load_dut(input bit from_idle);
    int n;
    if (from_idle) begin
      n = 0;
      while (!bus.din_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.din_ready) check("rekey_idle_timeout", 0, 1);
    end
    for (int m = 0; m < 256; m++) begin
      bus.sbox_wr_en     = 1'b1;
      bus.sbox_wr_addr   = 8'(m);
      bus.sbox_wr_data   = 8'(ks_s[m]);
      bus.sbox_load_done = (m == 255);
      @(negedge clk);
      if (m == 0 && from_idle) check("rekey_loaded_fall", bus.sbox_loaded, 0);
    end
    bus.sbox_wr_en     = 1'b0;
    bus.sbox_load_done = 1'b0;
    check("load_sbox_loaded", bus.sbox_loaded, 1);
    check("load_din_ready", bus.din_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] e, input bit expect_out);
    int n;
    bus.din       = d;
    bus.din_valid = 1'b1;
    n = 0;
    while (!bus.din_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.din_ready) begin
      check("accept_timeout", 0, 1);
      bus.din_valid = 1'b0;
      return;
    end
    if (expect_out) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] d);
    logic [7:0] k;
    ks_next(k);
    send_byte(d, d ^ k, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor samples shortly after the falling edge, once the driver has updated its inputs.
  bit prev_valid;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.dout_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency", cyc - acc_q.pop_front(), 3);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dout", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("TXN t=%0d dout=%02h expected=%02h", cyc, bus.dout, e);
          check("dout", bus.dout, e);
        end
      end
      prev_valid = bus.dout_valid;
    end
  end

  initial begin
    logic [7:0] e;
    logic [7:0] k;
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.sbox_wr_en     = 1'b0;
    bus.sbox_wr_addr   = '0;
    bus.sbox_wr_data   = '0;
    bus.sbox_load_done = 1'b0;
    bus.din            = '0;
    bus.din_valid      = 1'b0;
    bus.dout_ready     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_sbox_loaded", bus.sbox_loaded, 0);
    check("rst_dout", bus.dout, 0);
    rst = 1'b1;
    @(negedge clk);

    // Data offered before any load must be refused.
    bus.din = 8'hAA;
    bus.din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("load_din_ready_low", bus.din_ready, 0);
      check("load_no_dout", bus.dout_valid, 0);
    end
    bus.din_valid = 1'b0;

    set_identity();
    load_dut(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, exp_id[i], 1'b1);
    wait_drain();

    // Rekey from IDLE after three bytes.
    ksa("Key");
    load_dut(1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'h00, exp_key0[i], 1'b1);
    wait_drain();

    ksa("Key");
    load_dut(1'b1);
    for (int i = 0; i < 9; i++) send_byte(pt[i], ct[i], 1'b1);
    wait_drain();

    ksa("Key");
    load_dut(1'b1);
    for (int i = 0; i < 9; i++) send_byte(ct[i], pt[i], 1'b1);
    wait_drain();

    // Backpressure, then a long run that wraps i past 255.
    ksa("Key");
    load_dut(1'b1);
    send_model(8'h11);
    wait_drain();
    bus.dout_ready = 1'b0;
    ks_next(k);
    e = 8'h22 ^ k;
    send_byte(8'h22, e, 1'b1);
    n = 0;
    while (!bus.dout_valid && n < 10) begin @(negedge clk); n++; end
    check("bp_valid_seen", bus.dout_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_dout", bus.dout, e);
      check("bp_valid", bus.dout_valid, 1);
      check("bp_din_ready", bus.din_ready, 0);
    end
    bus.dout_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < 258; i++) send_model(8'($urandom_range(0, 255)));
    wait_drain();

    // Reset while a byte is in KEY.
    bus.din = 8'h55;
    bus.din_valid = 1'b1;
    n = 0;
    while (!bus.din_ready && n < 50) begin @(negedge clk); n++; end
    check("abort_accept", bus.din_ready, 1);
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_dout_valid", bus.dout_valid, 0);
    check("abort_sbox_loaded", bus.sbox_loaded, 0);
    check("abort_din_ready", bus.din_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.din = 8'h33;
    bus.din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_din_ready", bus.din_ready, 0);
      check("post_rst_no_dout", bus.dout_valid, 0);
    end
    bus.din_valid = 1'b0;
    set_identity();
    load_dut(1'b0);
    send_byte(8'h00, 8'h02, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
